// File: rtl/mult_share_arbiter.sv
// Round-robin front end that shares one sequential 4x4 multiplier between two requesters.
// Optional WAIT-state timeout (err + zero result) is compiled in when MULT_ARB_TIMEOUT_EN is defined.
module mult_share_arbiter #(
  parameter int unsigned START_CYCLES = 1,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [3:0] dataa0,
  input  logic [3:0] datab0,
  input  logic       req1,
  input  logic [3:0] dataa1,
  input  logic [3:0] datab1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       err,
  output logic [7:0] result,
  output logic       mul_start,
  output logic [3:0] mul_dataa,
  output logic [3:0] mul_datab,
  input  logic       mul_done,
  input  logic [7:0] mul_product
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic [1:0] START_LAST = 2'(START_CYCLES - 1);

  // Out-of-range parameters leave this block populated so they show up in the elaborated hierarchy.
  if ((START_CYCLES < 1) || (START_CYCLES > 3) || (TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_param_out_of_range
  end

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       done0_q, done0_d;
  logic       done1_q, done1_d;
  logic       err_q, err_d;
  logic [7:0] result_q, result_d;
  logic       mul_start_q, mul_start_d;
  logic [3:0] dataa_q, dataa_d;
  logic [3:0] datab_q, datab_d;
  logic [1:0] start_cnt_q, start_cnt_d;
  logic       wait_first_q, wait_first_d;
  logic       pick1_s;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
`endif

  // last_q = 1 means requester 1 was served last, so a tie goes to requester 0.
  assign pick1_s = req1 & (~req0 | ~last_q);

  // Next-state and registered-output logic for the IDLE/LOAD/WAIT/RESP sequence.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gnt0_d       = gnt0_q;
    gnt1_d       = gnt1_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    err_d        = 1'b0;
    result_d     = result_q;
    mul_start_d  = mul_start_q;
    dataa_d      = dataa_q;
    datab_d      = datab_q;
    start_cnt_d  = start_cnt_q;
    wait_first_d = wait_first_q;
`ifdef MULT_ARB_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_d     = ST_LOAD;
          last_d      = pick1_s;
          gnt0_d      = ~pick1_s;
          gnt1_d      = pick1_s;
          mul_start_d = 1'b1;
          start_cnt_d = 2'd0;
          dataa_d     = pick1_s ? dataa1 : dataa0;
          datab_d     = pick1_s ? datab1 : datab0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (start_cnt_q == START_LAST) begin
          mul_start_d  = 1'b0;
          wait_first_d = 1'b1;
          state_d      = ST_WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
          tmo_cnt_d    = 8'd0;
`endif
        end else begin
          start_cnt_d = start_cnt_q + 2'd1;
        end
      end
      ST_WAIT: begin
        // A done level still high from the previous operation is ignored on the first WAIT cycle.
        wait_first_d = 1'b0;
        if (!wait_first_q && mul_done) begin
          result_d = mul_product;
          done0_d  = gnt0_q;
          done1_d  = gnt1_q;
          state_d  = ST_RESP;
        end else begin
`ifdef MULT_ARB_TIMEOUT_EN
          if (tmo_cnt_q == TIMEOUT_LAST) begin
            result_d = 8'd0;
            err_d    = 1'b1;
            done0_d  = gnt0_q;
            done1_d  = gnt1_q;
            state_d  = ST_RESP;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
          end
`else
          state_d = ST_WAIT;
`endif
        end
      end
      ST_RESP: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        mul_start_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State, pointer, operand and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_q       <= 1'b1;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err_q        <= 1'b0;
      result_q     <= 8'd0;
      mul_start_q  <= 1'b0;
      dataa_q      <= 4'd0;
      datab_q      <= 4'd0;
      start_cnt_q  <= 2'd0;
      wait_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      err_q        <= err_d;
      result_q     <= result_d;
      mul_start_q  <= mul_start_d;
      dataa_q      <= dataa_d;
      datab_q      <= datab_d;
      start_cnt_q  <= start_cnt_d;
      wait_first_q <= wait_first_d;
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  // WAIT-cycle counter for the abort path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= 8'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign err       = err_q;
  assign result    = result_q;
  assign mul_start = mul_start_q;
  assign mul_dataa = dataa_q;
  assign mul_datab = datab_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter with a behavioural multiplier model.
// Timeout scenario is included only when MULT_ARB_TIMEOUT_EN is defined.
module tb_mult_share_arbiter;

  localparam int SC = 1;
  localparam int TO = 15;
  // Model raises done on the 4th negedge after mul_start drops; +1 capture, +1 response cycle.
  localparam int LAT_OK = SC + 5;

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic [3:0] dataa0, datab0, dataa1, datab1;
  logic       gnt0, gnt1, done0, done1, err;
  logic [7:0] result;
  logic       mul_start;
  logic [3:0] mul_dataa, mul_datab;
  logic       mul_done;
  logic [7:0] mul_product;

  int total = 0;
  int bad = 0;
  int model_mode = 0;  // 0 normal, 1 stale done on first WAIT cycle, 2 never done
  int pulses = 0;
  int exp_pulses = 0;
  int both_hi = 0;
  int wide_done = 0;
  int start_bad = 0;
  int ref_last = 1;

  mult_share_arbiter #(.START_CYCLES(SC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .dataa0(dataa0), .datab0(datab0),
    .req1(req1), .dataa1(dataa1), .datab1(datab1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
    .result(result), .mul_start(mul_start), .mul_dataa(mul_dataa), .mul_datab(mul_datab),
    .mul_done(mul_done), .mul_product(mul_product)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural multiplier: latches operands while start is high, answers a*b later.
  initial begin
    bit         m_busy;
    int         m_cnt;
    logic [3:0] m_a, m_b;
    m_busy = 1'b0;
    m_cnt = 0;
    mul_done = 1'b0;
    mul_product = 8'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 1'b0;
        m_cnt = 0;
        mul_done = 1'b0;
      end else if (mul_start) begin
        m_busy = 1'b1;
        m_cnt = 0;
        mul_done = 1'b0;
        m_a = mul_dataa;
        m_b = mul_datab;
      end else if (m_busy) begin
        m_cnt++;
        if (m_cnt == 1 && model_mode == 1) begin
          mul_done = 1'b1;
          mul_product = 8'hAA;
        end else if (m_cnt == 2 && model_mode == 1) begin
          mul_done = 1'b0;
        end
        if (m_cnt == 4 && model_mode != 2) begin
          mul_done = 1'b1;
          mul_product = 8'(int'(m_a) * int'(m_b));
          m_busy = 1'b0;
        end
      end
    end
  end

  // Protocol monitor: grant exclusivity, done pulse width and mul_start run length.
  initial begin
    bit prev_done;
    int srun;
    prev_done = 1'b0;
    srun = 0;
    forever begin
      @(negedge clk);
      if (gnt0 && gnt1) both_hi++;
      if (done0 && done1) both_hi++;
      if (done0 || done1) begin
        pulses++;
        if (prev_done) wide_done++;
      end
      prev_done = done0 || done1;
      if (mul_start) begin
        srun++;
      end else begin
        if (srun != 0 && srun != SC) start_bad++;
        srun = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Starts at a negedge in IDLE, returns at the negedge of the following IDLE cycle.
  task automatic do_op(input string tag, input logic r0, input logic r1,
                       input logic [3:0] a0, input logic [3:0] b0,
                       input logic [3:0] a1, input logic [3:0] b1,
                       input int exp_who, input int exp_res, input int exp_err,
                       input int exp_lat, input bit hold);
    bit got;
    int lat;
    logic d0, d1, g0, g1, e;
    logic [7:0] res;
    logic [3:0] ma, mb;
    req0 = r0; req1 = r1;
    dataa0 = a0; datab0 = b0; dataa1 = a1; datab1 = b1;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100 && !got; k++) begin
      @(negedge clk);
      if (done0 || done1) begin
        got = 1'b1;
        lat = k;
        d0 = done0; d1 = done1; g0 = gnt0; g1 = gnt1;
        e = err; res = result; ma = mul_dataa; mb = mul_datab;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s_no_done: no done pulse within 100 cycles", tag);
    end else begin
      exp_pulses++;
      check({tag, "_done0"}, 32'(d0), 32'(exp_who == 0));
      check({tag, "_done1"}, 32'(d1), 32'(exp_who == 1));
      check({tag, "_gnt0"}, 32'(g0), 32'(exp_who == 0));
      check({tag, "_gnt1"}, 32'(g1), 32'(exp_who == 1));
      check({tag, "_result"}, 32'(res), 32'(exp_res));
      check({tag, "_err"}, 32'(e), 32'(exp_err));
      check({tag, "_dataa"}, 32'(ma), 32'(exp_who == 1 ? a1 : a0));
      check({tag, "_datab"}, 32'(mb), 32'(exp_who == 1 ? b1 : b0));
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    end
    if (!hold) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
    @(negedge clk);
    check({tag, "_idle_outs"}, 32'({gnt0, gnt1, done0, done1}), 32'd0);
  endtask

  typedef struct {
    logic       r0;
    logic       r1;
    logic [3:0] a0, b0, a1, b1;
    int         who;
    int         res;
  } vec_t;

  initial begin
    vec_t vt[8];
    int rq, w, er, pb;
    logic [3:0] ra0, rb0, ra1, rb1;

    vt[0] = '{1'b1, 1'b0, 4'd3,  4'd5,  4'd0,  4'd0,  0, 15};
    vt[1] = '{1'b0, 1'b1, 4'd0,  4'd0,  4'd15, 4'd15, 1, 225};
    vt[2] = '{1'b1, 1'b1, 4'd2,  4'd7,  4'd9,  4'd4,  0, 14};
    vt[3] = '{1'b1, 1'b1, 4'd2,  4'd7,  4'd9,  4'd4,  1, 36};
    vt[4] = '{1'b1, 1'b1, 4'd0,  4'd9,  4'd8,  4'd8,  0, 0};
    vt[5] = '{1'b0, 1'b1, 4'd4,  4'd4,  4'd1,  4'd15, 1, 15};
    vt[6] = '{1'b1, 1'b0, 4'd15, 4'd15, 4'd3,  4'd3,  0, 225};
    vt[7] = '{1'b1, 1'b1, 4'd10, 4'd3,  4'd12, 4'd2,  1, 24};

    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    dataa0 = 4'd0; datab0 = 4'd0; dataa1 = 4'd0; datab1 = 4'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_gnt0", 32'(gnt0), 32'd0);
    check("reset_gnt1", 32'(gnt1), 32'd0);
    check("reset_done", 32'({done0, done1}), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_start", 32'(mul_start), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_dataa", 32'(mul_dataa), 32'd0);
    check("reset_datab", 32'(mul_datab), 32'd0);

    for (int i = 0; i < 8; i++) begin
      do_op($sformatf("vec%0d", i), vt[i].r0, vt[i].r1, vt[i].a0, vt[i].b0,
            vt[i].a1, vt[i].b1, vt[i].who, vt[i].res, 0, LAT_OK, 1'b0);
      ref_last = vt[i].who;
    end

    model_mode = 1;
    do_op("stale_done", 1'b1, 1'b0, 4'd6, 4'd6, 4'd0, 4'd0, 0, 36, 0, LAT_OK, 1'b0);
    ref_last = 0;

    for (int i = 0; i < 40; i++) begin
      rq = $urandom_range(1, 3);
      model_mode = $urandom_range(0, 1);
      ra0 = 4'($urandom_range(0, 15)); rb0 = 4'($urandom_range(0, 15));
      ra1 = 4'($urandom_range(0, 15)); rb1 = 4'($urandom_range(0, 15));
      if (rq == 3) w = 1 - ref_last;
      else w = (rq == 2) ? 1 : 0;
      do_op($sformatf("rnd%0d", i), rq[0], rq[1], ra0, rb0, ra1, rb1, w,
            (w == 1) ? int'(ra1) * int'(rb1) : int'(ra0) * int'(rb0), 0, LAT_OK, 1'b0);
      ref_last = w;
    end

    model_mode = 2;
    req0 = 1'b1; dataa0 = 4'd7; datab0 = 4'd7;
    repeat (SC + 2) @(negedge clk);
    check("rst_pre_gnt0", 32'(gnt0), 32'd1);
    check("rst_pre_start", 32'(mul_start), 32'd0);
    pb = pulses;
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_ctrl", 32'({gnt0, gnt1, done0, done1, err, mul_start}), 32'd0);
    check("rst_async_result", 32'(result), 32'd0);
    check("rst_async_data", 32'({mul_dataa, mul_datab}), 32'd0);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ref_last = 1;
    model_mode = 0;
    repeat (2) @(negedge clk);
    check("rst_no_done", 32'(pulses), 32'(pb));

    for (int i = 0; i < 4; i++) begin
      w = 1 - ref_last;
      do_op($sformatf("alt%0d", i), 1'b1, 1'b1, 4'd2, 4'd7, 4'd9, 4'd4, w,
            (w == 1) ? 36 : 14, 0, LAT_OK, (i < 3));
      ref_last = w;
    end

`ifdef MULT_ARB_TIMEOUT_EN
    model_mode = 2;
    w = 1 - ref_last;
    do_op("timeout", 1'b1, 1'b1, 4'd5, 4'd5, 4'd5, 4'd5, w, 0, 1, SC + 1 + TO, 1'b0);
    ref_last = w;
    model_mode = 0;
    w = 1 - ref_last;
    do_op("after_timeout", 1'b1, 1'b1, 4'd3, 4'd3, 4'd4, 4'd4, w,
          (w == 1) ? 16 : 9, 0, LAT_OK, 1'b0);
    ref_last = w;
`endif
    er = 0;
    #1;
    check("no_dual_grant_or_done", 32'(both_hi), 32'(er));
    check("done_one_cycle", 32'(wide_done), 32'(er));
    check("start_length", 32'(start_bad), 32'(er));
    check("done_pulse_count", 32'(pulses), 32'(exp_pulses));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
